// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the priority-select ALU: FIFO-buffers (op,a,b) commands and presents a registered
// one-hot sel/a/b with valid/ready. Define ALU_SEQ_ERR_EN to drop op 6/7 and flag them in err_sticky.
module alu_cmd_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [W-1:0]           cmd_a,
  input  logic [W-1:0]           cmd_b,
  output logic [5:0]             sel,
  output logic [W-1:0]           a,
  output logic [W-1:0]           b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
`ifdef ALU_SEQ_ERR_EN
  output logic                   err_sticky,
  input  logic                   err_clr,
`endif
  output logic [CNT_W-1:0]       issued_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = 6 + 2 * W;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          full, empty;
  logic          push, fifo_push, pop;
  logic          legal;
  logic [5:0]    enc_sel;
  logic [EW-1:0] head;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;

  assign cmd_ready = ~full;
  assign push      = cmd_valid & cmd_ready;
  assign legal     = (cmd_op < 3'd6);

`ifdef ALU_SEQ_ERR_EN
  assign fifo_push = push & legal;
`else
  assign fifo_push = push;
`endif

  // Load the output register whenever it is empty or being consumed this cycle.
  assign pop  = (~out_valid | out_ready) & ~empty;
  assign head = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    enc_sel = '0;
    if (legal) begin
      enc_sel = 6'b000001 << cmd_op;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (fifo_push) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {enc_sel, cmd_a, cmd_b};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel       <= '0;
      a         <= '0;
      b         <= '0;
      out_valid <= 1'b0;
    end else if (pop) begin
      {sel, a, b} <= head;
      out_valid   <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_cnt <= '0;
    end else if (out_valid && out_ready) begin
      issued_cnt <= issued_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

`ifdef ALU_SEQ_ERR_EN
  // An illegal push in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
    end else if (push && !legal) begin
      err_sticky <= 1'b1;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomized + directed scoreboard bench for alu_cmd_sequencer; honours ALU_SEQ_ERR_EN if defined.
module tb_alu_cmd_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned W     = 4;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid, cmd_ready;
  logic [2:0]       cmd_op;
  logic [W-1:0]     cmd_a, cmd_b;
  logic [5:0]       sel;
  logic [W-1:0]     a, b;
  logic             out_valid, out_ready;
  logic [2:0]       level;
  logic [CNT_W-1:0] issued_cnt;
`ifdef ALU_SEQ_ERR_EN
  logic             err_sticky, err_clr;
`endif

  alu_cmd_sequencer #(
    .DEPTH (DEPTH),
    .W     (W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .sel        (sel),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .level      (level),
`ifdef ALU_SEQ_ERR_EN
    .err_sticky (err_sticky),
    .err_clr    (err_clr),
`endif
    .issued_cnt (issued_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          n_issued = 0;
  logic [13:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [13:0] prev_out = '0;

  // ALU select for each opcode: add,sub,and,xor,~a,~b are one-hot bits 0..5; 6/7 select nothing.
  function automatic logic [5:0] sel_of(input logic [2:0] op);
    case (op)
      3'd0:    return 6'h01;
      3'd1:    return 6'h02;
      3'd2:    return 6'h04;
      3'd3:    return 6'h08;
      3'd4:    return 6'h10;
      3'd5:    return 6'h20;
      default: return 6'h00;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Observes the cycle about to close: issued outputs are popped and compared, accepted
  // commands are queued as expected issues.
  task automatic monitor_step();
    logic [13:0] cur, e;
    cur = {sel, a, b};
    if (prev_stall) chk("stall_hold", {17'd0, out_valid, cur}, {17'd0, 1'b1, prev_out});
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_issue", {31'd0, out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("issue_data", {18'd0, cur}, {18'd0, e});
        n_issued++;
      end
    end
    if (cmd_valid && cmd_ready) begin
`ifdef ALU_SEQ_ERR_EN
      if (cmd_op < 3'd6)
`endif
        exp_q.push_back({sel_of(cmd_op), cmd_a, cmd_b});
    end
    prev_stall = out_valid && !out_ready;
    prev_out   = cur;
  endtask

  task automatic send(input logic [2:0] op, input logic [W-1:0] va, input logic [W-1:0] vb);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = va;
    cmd_b     = vb;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("send_timeout", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("drain_done", exp_q.size(), 32'd0);
    step();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    out_ready = 1'b0;
    #2;
    exp_q.delete();
    n_issued   = 0;
    prev_stall = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sel", {26'd0, sel}, 32'd0);
    chk("rst_a", {28'd0, a}, 32'd0);
    chk("rst_b", {28'd0, b}, 32'd0);
    chk("rst_level", {29'd0, level}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_issued_cnt", {24'd0, issued_cnt}, 32'd0);
`ifdef ALU_SEQ_ERR_EN
    chk("rst_err_sticky", {31'd0, err_sticky}, 32'd0);
`endif
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] rel_seq [5];
    logic [2:0] fill_ops [5];
    int         base;
    rel_seq  = '{6'h01, 6'h04, 6'h08, 6'h10, 6'h20};
    fill_ops = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd5};
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    out_ready = 1'b0;
`ifdef ALU_SEQ_ERR_EN
    err_clr = 1'b0;
`endif
    fork
      forever begin
        @(negedge clk);
        if (rst_n) monitor_step();
      end
    join_none

    do_reset();

    // Single command: pushed at edge N, valid after N+1, counted after N+2.
    out_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 3'd1;
    cmd_a     = 4'hF;
    cmd_b     = 4'h3;
    @(negedge clk);
    chk("single_ready", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("single_no_bypass", {31'd0, out_valid}, 32'd0);
    step();
    @(negedge clk);
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_sel", {26'd0, sel}, 32'h02);
    chk("single_a", {28'd0, a}, 32'hF);
    chk("single_b", {28'd0, b}, 32'h3);
    step();
    chk("single_cnt", {24'd0, issued_cnt}, 32'd1);

    // Backpressure fill, then release one per cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(fill_ops[i], 4'($urandom), 4'($urandom));
    @(negedge clk);
    chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("bp_level", {29'd0, level}, 32'd4);
    chk("bp_sel_head", {26'd0, sel}, 32'h01);
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_release_sel", {26'd0, sel}, {26'd0, rel_seq[i]});
      chk("bp_release_valid", {31'd0, out_valid}, 32'd1);
    end
    drain();

    // Full with a pop in the same cycle: push refused, then accepted next cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(3'($urandom_range(0, 5)), 4'($urandom), 4'($urandom));
    cmd_valid = 1'b1;
    cmd_op    = 3'd3;
    cmd_a     = 4'hA;
    cmd_b     = 4'h5;
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_refuse", {31'd0, cmd_ready}, 32'd0);
    chk("full_level", {29'd0, level}, 32'd4);
    step();
    @(negedge clk);
    chk("full_reaccept", {31'd0, cmd_ready}, 32'd1);
    chk("full_level_after_pop", {29'd0, level}, 32'd3);
    step();
    cmd_valid = 1'b0;
    drain();

    // Reset with work in flight discards everything at once.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(3'($urandom_range(0, 5)), 4'($urandom), 4'($urandom));
    @(negedge clk);
    chk("midrst_level_before", {29'd0, level}, 32'd2);
    step();
    do_reset();

    // 300 back-to-back commands from reset: counter wraps to 44.
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) send(3'($urandom_range(0, 5)), 4'($urandom), 4'($urandom));
    drain();
    chk("wrap_n_issued", n_issued, 32'd300);
    chk("wrap_issued_cnt", {24'd0, issued_cnt}, 32'd44);

    // Opcode 6 handling.
    base = n_issued;
    out_ready = 1'b1;
`ifdef ALU_SEQ_ERR_EN
    send(3'd6, 4'h5, 4'h9);
    @(negedge clk);
    chk("op6_err_set", {31'd0, err_sticky}, 32'd1);
    chk("op6_not_queued", {29'd0, level}, 32'd0);
    chk("op6_not_issued_valid", {31'd0, out_valid}, 32'd0);
    step();
    drain();
    chk("op6_dropped", n_issued - base, 32'd0);
    err_clr   = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 3'd7;
    step();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("err_clr_vs_illegal", {31'd0, err_sticky}, 32'd1);
    step();
    @(negedge clk);
    chk("err_clr", {31'd0, err_sticky}, 32'd0);
    err_clr = 1'b0;
    step();
`else
    send(3'd6, 4'h5, 4'h9);
    drain();
    chk("op6_issued", n_issued - base, 32'd1);
    chk("op6_cnt", {24'd0, issued_cnt}, {24'd0, 8'(n_issued)});
`endif

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      cmd_valid = 1'($urandom);
      cmd_op    = 3'($urandom);
      cmd_a     = 4'($urandom);
      cmd_b     = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    cmd_valid = 1'b0;
    drain();
    chk("rand_issued_cnt", {24'd0, issued_cnt}, {24'd0, 8'(n_issued)});
    chk("rand_level_empty", {29'd0, level}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
